// File: rtl/double_to_long_arbiter_pkg.sv
// rtl/double_to_long_arbiter_pkg.sv - shared types and constants for the double-to-long arbiter
package double_to_long_arbiter_pkg;

    localparam int DEF_N  = 4;
    localparam int DEF_GW = 2;
    localparam int WORD_W = 64;

    typedef enum logic [2:0] {
        ARB    = 3'd0,
        ACCEPT = 3'd1,
        SEND   = 3'd2,
        WAIT   = 3'd3,
        RETURN = 3'd4
    } state_t;

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational cyclic priority encoder starting at ptr
module rr_pick
    import double_to_long_arbiter_pkg::*;
#(
    parameter int N  = DEF_N,
    parameter int GW = DEF_GW
) (
    input  logic [N-1:0]  req,
    input  logic [GW-1:0] ptr,
    output logic [GW-1:0] idx,
    output logic          any
);

    // Scan offsets from farthest to nearest so the nearest set bit at or above ptr wins.
    always_comb begin : pick
        int j;
        idx = '0;
        any = 1'b0;
        for (int k = N - 1; k >= 0; k--) begin
            j = int'(ptr) + k;
            if (j >= N) begin
                j = j - N;
            end
            if (req[j]) begin
                idx = GW'(j);
                any = 1'b1;
            end
        end
    end

endmodule

// File: rtl/double_to_long_arbiter.sv
// rtl/double_to_long_arbiter.sv - round-robin sharing of one double-to-long converter
module double_to_long_arbiter
    import double_to_long_arbiter_pkg::*;
#(
    parameter int N  = DEF_N,
    parameter int GW = DEF_GW
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [N*WORD_W-1:0]   req_a,
    input  logic [N-1:0]          req_a_stb,
    output logic [N-1:0]          req_a_ack,
    output logic [WORD_W-1:0]     rsp_z,
    output logic [N-1:0]          rsp_z_stb,
    input  logic [N-1:0]          rsp_z_ack,
    output logic [WORD_W-1:0]     conv_a,
    output logic                  conv_a_stb,
    input  logic                  conv_a_ack,
    input  logic [WORD_W-1:0]     conv_z,
    input  logic                  conv_z_stb,
    output logic                  conv_z_ack,
    output logic [GW-1:0]         grant,
    output logic                  busy
);

    state_t             state_q, state_d;
    logic [GW-1:0]      ptr_q, ptr_d;
    logic [GW-1:0]      grant_q, grant_d;
    logic [N-1:0]       req_a_ack_q, req_a_ack_d;
    logic [N-1:0]       rsp_z_stb_q, rsp_z_stb_d;
    logic [WORD_W-1:0]  conv_a_q, conv_a_d;
    logic [WORD_W-1:0]  rsp_z_q, rsp_z_d;
    logic               conv_a_stb_q, conv_a_stb_d;
    logic               conv_z_ack_q, conv_z_ack_d;
    logic               busy_q, busy_d;

    logic [GW-1:0]      pick_idx;
    logic               pick_any;

    rr_pick #(
        .N  (N),
        .GW (GW)
    ) u_rr_pick (
        .req (req_a_stb),
        .ptr (ptr_q),
        .idx (pick_idx),
        .any (pick_any)
    );

    // Next-state and next-output logic; every output is the registered copy of its _d.
    always_comb begin
        state_d      = state_q;
        ptr_d        = ptr_q;
        grant_d      = grant_q;
        req_a_ack_d  = req_a_ack_q;
        rsp_z_stb_d  = rsp_z_stb_q;
        conv_a_d     = conv_a_q;
        rsp_z_d      = rsp_z_q;
        conv_a_stb_d = conv_a_stb_q;
        conv_z_ack_d = conv_z_ack_q;
        case (state_q)
            ARB: begin
                if (pick_any) begin
                    grant_d     = pick_idx;
                    req_a_ack_d = N'(1) << pick_idx;
                    state_d     = ACCEPT;
                end
            end
            ACCEPT: begin
                if (req_a_stb[grant_q] && req_a_ack_q[grant_q]) begin
                    conv_a_d     = req_a[int'(grant_q)*WORD_W +: WORD_W];
                    req_a_ack_d  = '0;
                    conv_a_stb_d = 1'b1;
                    state_d      = SEND;
                end
            end
            SEND: begin
                if (conv_a_stb_q && conv_a_ack) begin
                    conv_a_stb_d = 1'b0;
                    conv_z_ack_d = 1'b1;
                    state_d      = WAIT;
                end
            end
            WAIT: begin
                if (conv_z_stb && conv_z_ack_q) begin
                    rsp_z_d      = conv_z;
                    conv_z_ack_d = 1'b0;
                    rsp_z_stb_d  = N'(1) << grant_q;
                    state_d      = RETURN;
                end
            end
            RETURN: begin
                if (rsp_z_stb_q[grant_q] && rsp_z_ack[grant_q]) begin
                    rsp_z_stb_d = '0;
                    ptr_d       = (grant_q == GW'(N - 1)) ? '0 : grant_q + 1'b1;
                    state_d     = ARB;
                end
            end
            default: begin
                state_d = ARB;
            end
        endcase
        busy_d = (state_d != ARB);
    end

    // State and output registers; reset clears everything, discarding any in-flight conversion.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ARB;
            ptr_q        <= '0;
            grant_q      <= '0;
            req_a_ack_q  <= '0;
            rsp_z_stb_q  <= '0;
            conv_a_q     <= '0;
            rsp_z_q      <= '0;
            conv_a_stb_q <= 1'b0;
            conv_z_ack_q <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            grant_q      <= grant_d;
            req_a_ack_q  <= req_a_ack_d;
            rsp_z_stb_q  <= rsp_z_stb_d;
            conv_a_q     <= conv_a_d;
            rsp_z_q      <= rsp_z_d;
            conv_a_stb_q <= conv_a_stb_d;
            conv_z_ack_q <= conv_z_ack_d;
            busy_q       <= busy_d;
        end
    end

    assign req_a_ack  = req_a_ack_q;
    assign rsp_z_stb  = rsp_z_stb_q;
    assign conv_a     = conv_a_q;
    assign rsp_z      = rsp_z_q;
    assign conv_a_stb = conv_a_stb_q;
    assign conv_z_ack = conv_z_ack_q;
    assign grant      = grant_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_double_to_long_arbiter.sv
// tb/tb_double_to_long_arbiter.sv - directed bench for double_to_long_arbiter
module tb_double_to_long_arbiter;

    logic          clk = 1'b0;
    logic          rst;
    logic [255:0]  req_a;
    logic [3:0]    req_a_stb;
    logic [3:0]    req_a_ack;
    logic [63:0]   rsp_z;
    logic [3:0]    rsp_z_stb;
    logic [3:0]    rsp_z_ack;
    logic [63:0]   conv_a;
    logic          conv_a_stb;
    logic          conv_a_ack;
    logic [63:0]   conv_z;
    logic          conv_z_stb;
    logic          conv_z_ack;
    logic [1:0]    grant;
    logic          busy;

    int passed = 0;
    int total  = 0;

    int acc_dly = 0;
    int lat_cfg = 1;
    int cst = 0;
    int cnt = 0;
    logic [63:0] op_lat;

    double_to_long_arbiter dut (
        .clk        (clk),
        .rst        (rst),
        .req_a      (req_a),
        .req_a_stb  (req_a_stb),
        .req_a_ack  (req_a_ack),
        .rsp_z      (rsp_z),
        .rsp_z_stb  (rsp_z_stb),
        .rsp_z_ack  (rsp_z_ack),
        .conv_a     (conv_a),
        .conv_a_stb (conv_a_stb),
        .conv_a_ack (conv_a_ack),
        .conv_z     (conv_z),
        .conv_z_stb (conv_z_stb),
        .conv_z_ack (conv_z_ack),
        .grant      (grant),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    // Truncating double-to-long; NaN, infinity and overflow give the integer indefinite value.
    function automatic logic [63:0] d2l(input logic [63:0] a);
        int e;
        logic [63:0] m;
        logic [63:0] mag;
        e = int'(a[62:52]);
        if (e == 2047 || e >= 1023 + 63) return 64'h8000_0000_0000_0000;
        if (e < 1023) return 64'h0;
        m = {11'b0, 1'b1, a[51:0]};
        if (e >= 1075) mag = m << (e - 1075);
        else mag = m >> (1075 - e);
        return a[63] ? -mag : mag;
    endfunction

    // Converter model with programmable accept delay and result latency.
    initial begin
        conv_a_ack = 1'b0;
        conv_z_stb = 1'b0;
        conv_z     = '0;
        op_lat     = '0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                conv_a_ack = 1'b0;
                conv_z_stb = 1'b0;
                cst = 0;
            end else begin
                case (cst)
                    0: if (conv_a_stb) begin
                        op_lat = conv_a;
                        cnt = acc_dly;
                        if (cnt == 0) begin conv_a_ack = 1'b1; cst = 2; end
                        else cst = 1;
                    end
                    1: begin
                        cnt--;
                        if (cnt == 0) begin conv_a_ack = 1'b1; cst = 2; end
                    end
                    2: begin conv_a_ack = 1'b0; cnt = lat_cfg; cst = 3; end
                    3: begin
                        cnt--;
                        if (cnt <= 0) begin conv_z = d2l(op_lat); conv_z_stb = 1'b1; cst = 4; end
                    end
                    default: begin conv_z_stb = 1'b0; cst = 0; end
                endcase
            end
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic set_req(input int idx, input logic [63:0] op);
        req_a[idx*64 +: 64] = op;
        req_a_stb[idx] = 1'b1;
    endtask

    task automatic take(input int idx, input logic [63:0] op, output int lat);
        int n;
        logic [3:0] oh;
        n = 0;
        oh = 4'(1) << idx;
        while (req_a_ack == 4'b0 && n < 100) begin @(negedge clk); n++; end
        lat = n;
        chk("accept_ack", 64'(req_a_ack), 64'(oh));
        chk("accept_grant", 64'(grant), 64'(idx));
        @(negedge clk);
        req_a_stb[idx] = 1'b0;
        chk("send_conv_a", conv_a, op);
        chk("send_stb", 64'(conv_a_stb), 64'd1);
        chk("send_ack_clear", 64'(req_a_ack), 64'd0);
    endtask

    task automatic give(input int idx, input logic [63:0] exp_z);
        int n;
        logic [3:0] oh;
        n = 0;
        oh = 4'(1) << idx;
        while (rsp_z_stb == 4'b0 && n < 200) begin @(negedge clk); n++; end
        chk("return_stb", 64'(rsp_z_stb), 64'(oh));
        chk("return_z", rsp_z, exp_z);
        rsp_z_ack[idx] = 1'b1;
        @(negedge clk);
        rsp_z_ack[idx] = 1'b0;
        chk("return_done", 64'(rsp_z_stb), 64'd0);
        chk("arb_idle", 64'(busy), 64'd0);
    endtask

    initial begin
        int lat;
        int n;
        int stbc;
        rst = 1'b0;
        req_a = '0;
        req_a_stb = '0;
        rsp_z_ack = '0;
        repeat (3) @(negedge clk);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_grant", 64'(grant), 64'd0);
        chk("rst_req_ack", 64'(req_a_ack), 64'd0);
        chk("rst_rsp_stb", 64'(rsp_z_stb), 64'd0);
        chk("rst_conv_stb", 64'({conv_a_stb, conv_z_ack}), 64'd0);
        chk("rst_conv_a", conv_a, 64'd0);
        chk("rst_rsp_z", rsp_z, 64'd0);
        rst = 1'b1;
        @(negedge clk);

        // single request on 2: 1.0 -> 1, ack one cycle after stb
        set_req(2, 64'h3FF0_0000_0000_0000);
        take(2, 64'h3FF0_0000_0000_0000, lat);
        chk("accept_latency", 64'(lat), 64'd1);
        give(2, 64'h0000_0000_0000_0001);

        // ptr is 3: requester 3 wins over 0, then wrap to 0
        set_req(0, 64'h7FF8_0000_0000_0000);
        set_req(3, 64'hC004_0000_0000_0000);
        take(3, 64'hC004_0000_0000_0000, lat);
        give(3, 64'hFFFF_FFFF_FFFF_FFFE);
        take(0, 64'h7FF8_0000_0000_0000, lat);
        give(0, 64'h8000_0000_0000_0000);

        // contention from reset: order 0,1,2,3 then 1,3
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        set_req(0, 64'h3FF0_0000_0000_0000);
        set_req(1, 64'h4000_0000_0000_0000);
        set_req(2, 64'hC004_0000_0000_0000);
        set_req(3, 64'h4059_0000_0000_0000);
        take(0, 64'h3FF0_0000_0000_0000, lat); give(0, 64'd1);
        take(1, 64'h4000_0000_0000_0000, lat); give(1, 64'd2);
        take(2, 64'hC004_0000_0000_0000, lat); give(2, 64'hFFFF_FFFF_FFFF_FFFE);
        take(3, 64'h4059_0000_0000_0000, lat); give(3, 64'd100);
        set_req(1, 64'h4059_0000_0000_0000);
        set_req(3, 64'h3FF0_0000_0000_0000);
        take(1, 64'h4059_0000_0000_0000, lat); give(1, 64'd100);
        take(3, 64'h3FF0_0000_0000_0000, lat); give(3, 64'd1);

        // backpressure on requester 0 while 1 waits and pulses a foreign rsp ack
        set_req(0, 64'h4059_0000_0000_0000);
        take(0, 64'h4059_0000_0000_0000, lat);
        n = 0;
        while (rsp_z_stb == 4'b0 && n < 200) begin @(negedge clk); n++; end
        set_req(1, 64'h4000_0000_0000_0000);
        rsp_z_ack[1] = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("bp_stb_hold", 64'(rsp_z_stb), 64'h1);
            chk("bp_z_hold", rsp_z, 64'd100);
            chk("bp_no_accept", 64'(req_a_ack), 64'd0);
        end
        rsp_z_ack[1] = 1'b0;
        rsp_z_ack[0] = 1'b1;
        @(negedge clk);
        rsp_z_ack[0] = 1'b0;
        chk("bp_complete", 64'(rsp_z_stb), 64'd0);
        take(1, 64'h4000_0000_0000_0000, lat);
        give(1, 64'd2);

        // converter stall: accept delayed 5, result delayed 20
        acc_dly = 5;
        lat_cfg = 20;
        set_req(2, 64'h4059_0000_0000_0000);
        take(2, 64'h4059_0000_0000_0000, lat);
        n = 0;
        stbc = 0;
        while (rsp_z_stb == 4'b0 && n < 200) begin
            chk("stall_busy", 64'(busy), 64'd1);
            if (conv_a_stb) begin
                stbc++;
                chk("stall_conv_a", conv_a, 64'h4059_0000_0000_0000);
            end
            @(negedge clk);
            n++;
        end
        chk("stall_stb_held", 64'(stbc >= 5), 64'd1);
        chk("stall_total", 64'(n >= 20), 64'd1);
        give(2, 64'd100);
        acc_dly = 0;

        // asynchronous reset while waiting on the converter
        set_req(1, 64'h4000_0000_0000_0000);
        take(1, 64'h4000_0000_0000_0000, lat);
        n = 0;
        while (!conv_z_ack && n < 50) begin @(negedge clk); n++; end
        chk("wait_reached", 64'(conv_z_ack), 64'd1);
        repeat (3) @(negedge clk);
        #1 rst = 1'b0;
        #1;
        chk("arst_busy", 64'(busy), 64'd0);
        chk("arst_grant", 64'(grant), 64'd0);
        chk("arst_conv_z_ack", 64'(conv_z_ack), 64'd0);
        chk("arst_stbs", 64'({req_a_ack, rsp_z_stb, conv_a_stb}), 64'd0);
        chk("arst_conv_a", conv_a, 64'd0);
        chk("arst_rsp_z", rsp_z, 64'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        lat_cfg = 1;
        @(negedge clk);
        set_req(1, 64'h4000_0000_0000_0000);
        take(1, 64'h4000_0000_0000_0000, lat);
        give(1, 64'd2);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule

// File: doc/double_to_long_arbiter.md
# double_to_long_arbiter

Round-robin arbiter that shares one double-to-long converter among N requesters. Each requester presents a 64-bit IEEE-754 double over a stb/ack handshake. The arbiter serialises the requests into the converter, one conversion in flight at a time, and returns the 64-bit signed result to the requester that issued it. It sits between the client blocks and the single converter instance.

## Interface
- N, default 4: number of requesters, 2..16.
- GW, default 2: grant index width, equal to clog2(N).
- clk  in  1  sole clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- req_a  in  N*64  request operands; slice i is bits [64i+63:64i].
- req_a_stb  in  N  request valid, one bit per requester.
- req_a_ack  out  N  request accept, one-hot or zero.
- rsp_z  out  64  result, shared by all requesters.
- rsp_z_stb  out  N  result valid, one-hot or zero.
- rsp_z_ack  in  N  result taken, one bit per requester.
- conv_a  out  64  operand to the converter.
- conv_a_stb  out  1  operand valid to the converter.
- conv_a_ack  in  1  converter accepts the operand.
- conv_z  in  64  converter result.
- conv_z_stb  in  1  converter result valid.
- conv_z_ack  out  1  arbiter accepts the result.
- grant  out  GW  index of the requester currently being served.
- busy  out  1  high in every state except ARB.

## Operation
- Transfer rule on every channel: a transfer occurs on a rising clk edge where stb and ack are both high.
  - Once raised, a stb is held, with stable data, until its transfer.
- All outputs are registered.
- State machine states: ARB, ACCEPT, SEND, WAIT, RETURN.
- ARB: if any req_a_stb is set, pick the first set bit at or above ptr, searching cyclically, and register it into grant; go to ACCEPT. If none is set, stay in ARB.
- ACCEPT: req_a_ack[grant]=1. On transfer:
  - latch req_a slice[grant] into conv_a;
  - clear ack;
  - set conv_a_stb=1;
  - go to SEND.
- SEND: hold conv_a_stb=1 until conv_a_ack. On transfer, clear conv_a_stb, set conv_z_ack=1, go to WAIT.
- WAIT: on conv_z_stb & conv_z_ack:
  - latch conv_z into rsp_z;
  - clear conv_z_ack;
  - set rsp_z_stb[grant]=1;
  - go to RETURN.
- RETURN: hold rsp_z_stb[grant] until rsp_z_ack[grant]. On transfer:
  - clear the stb;
  - ptr <= (grant+1) mod N;
  - go to ARB.
- The conversion result is passed through unmodified. The arbiter performs no arithmetic on data.
- ptr is a GW-bit register. The wrap from N-1 goes to 0, including when N is not a power of two.
- rsp_z_ack bits of non-granted requesters, and req_a_stb changes on non-granted lines, are ignored.
- Reset (rst low, any state, including mid-conversion):
  - state=ARB, ptr=0, grant=0, busy=0;
  - all stb/ack outputs = 0;
  - conv_a=0, rsp_z=0.
  - An in-flight conversion is discarded. The converter is reset by the same system reset.

## Timing
- Minimum request-to-accept latency: 1 cycle in ARB, then ack is high in the first ACCEPT cycle.
- Minimum total occupancy per request is 4 arbiter cycles plus the converter latency:
  - ARB 1;
  - ACCEPT ≥1;
  - SEND ≥1;
  - WAIT = converter latency;
  - RETURN ≥1.
- Back-to-back: the cycle after the RETURN transfer is ARB. No bubble-free overlap; throughput is one conversion at a time.
- Fairness: a requester holding stb waits for at most N-1 other services before being granted.

## Structure
- Shared package double_to_long_arbiter_pkg holds:
  - the state enum (ARB=0, ACCEPT=1, SEND=2, WAIT=3, RETURN=4, 3-bit);
  - the default N and GW;
  - the word width constant 64.
- One sub-module, rr_pick: a combinational cyclic priority encoder.
  - Inputs: req[N], ptr[GW].
  - Outputs: idx[GW], any.
  - It is reused by other shared-resource arbiters in the FPU cluster.

## Test plan
- Single request: requester 2 sends 0x3FF0000000000000 (1.0).
  - Expect req_a_ack[2] in the cycle after stb.
  - Expect conv_a=0x3FF0000000000000.
  - Expect rsp_z=0x0000000000000001 with rsp_z_stb=0b0100, then ptr=3.
- Sign and truncation: 0xC004000000000000 (-2.5) → rsp_z=0xFFFFFFFFFFFFFFFE. 0x7FF8000000000000 (NaN) → 0x8000000000000000.
- Contention: all 4 stb raised together from reset.
  - Expect grant order 0,1,2,3 and each result routed only to its own rsp_z_stb bit.
  - Then re-raise 1 and 3 with ptr=0: order 1,3.
- Backpressure: hold rsp_z_ack[0]=0 for 10 cycles.
  - rsp_z_stb[0] and rsp_z stay stable.
  - No new req_a_ack while RETURN is pending.
  - Completion takes 1 cycle after ack rises.
- Converter stall: conv_a_ack low 5 cycles, then conv_z_stb delayed 20 cycles. conv_a and conv_a_stb stay stable; busy=1 throughout.
- Reset mid-WAIT: drop rst asynchronously.
  - All outputs go to 0 immediately, without waiting for a clk edge.
  - After release, a fresh request on requester 1 completes normally with grant=1.
